// File: rtl/hazard_ctrl_pkg.sv
// Purpose: shared encodings and helpers for the pipeline hazard controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package hazard_ctrl_pkg;

  // Result-select encodings carried in the pipeline control registers.
  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  // EX operand forwarding selects.
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // Data-memory handshake states.
  typedef enum logic {
    S_RUN  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Forward select for one EX source register. M is younger than W, so it
  // wins when both write the same register. x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rdm,
    input logic [4:0] rdw,
    input logic       regwritem,
    input logic       regwritew
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (rs != 5'd0 && regwritem && rs == rdm) begin
      sel = FWD_M;
    end else if (rs != 5'd0 && regwritew && rs == rdw) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_hz_forward.sv
// Purpose: EX-stage operand forwarding selects for both source registers.
// Latency: combinational, same cycle.
// Backpressure: none; pure function of the E/M/W register fields.
//
// Ports:
//   rs1e, rs2e            in  source registers of the instruction in E
//   rdm, rdw              in  destinations in M and W
//   regwritem, regwritew  in  write enables in M and W
//   forwardae, forwardbe  out operand selects (00 RF, 01 W, 10 M)
module hz_forward
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1e,
  input  logic [4:0] rs2e,
  input  logic [4:0] rdm,
  input  logic [4:0] rdw,
  input  logic       regwritem,
  input  logic       regwritew,
  output logic [1:0] forwardae,
  output logic [1:0] forwardbe
);

  always_comb begin
    forwardae = fwd_sel(rs1e, rdm, rdw, regwritem, regwritew);
    forwardbe = fwd_sel(rs2e, rdm, rdw, regwritem, regwritew);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Purpose: stall/flush sequencing, forwarding and data-memory handshake for the 5-stage core.
// Latency: stall/flush/forward/dmem_req combinational; state, mem_err, stall_cnt update on clk.
// Backpressure: freezes the whole pipe while a MEM access waits on dmem_ready, up to TIMEOUT cycles.
//
// Ports:
//   clk, reset_n                      core clock, async active-low reset
//   rs1d, rs2d                        sources of the instruction in D
//   rs1e, rs2e, rde, resultsrce       sources, destination and result select in E
//   pcsrce                            taken branch/jump resolved in E
//   rdm, rdw, regwritem, regwritew    destinations and write enables in M and W
//   memwritem, resultsrcm             store flag and result select in M
//   dmem_ready / dmem_req             data-memory completion / access outstanding
//   forwardae, forwardbe              EX operand selects
//   stallf/d/e/m, flushd/e/w          pipeline register enables
//   mem_err                           sticky access-timeout flag
//   stall_cnt                         saturating count of stalld cycles
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       rs1d,
  input  logic [4:0]       rs2d,
  input  logic [4:0]       rs1e,
  input  logic [4:0]       rs2e,
  input  logic [4:0]       rde,
  input  logic [1:0]       resultsrce,
  input  logic             pcsrce,
  input  logic [4:0]       rdm,
  input  logic [4:0]       rdw,
  input  logic             regwritem,
  input  logic             regwritew,
  input  logic             memwritem,
  input  logic [1:0]       resultsrcm,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic [1:0]       forwardae,
  output logic [1:0]       forwardbe,
  output logic             stallf,
  output logic             stalld,
  output logic             stalle,
  output logic             stallm,
  output logic             flushd,
  output logic             flushe,
  output logic             flushw,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WCNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);

  state_t            state;
  logic [WCNT_W-1:0] wcnt;
  logic              macc;
  logic              lwstall;
  logic              memstall;
  logic              abort;

  hz_forward u_fwd (
    .rs1e      (rs1e),
    .rs2e      (rs2e),
    .rdm       (rdm),
    .rdw       (rdw),
    .regwritem (regwritem),
    .regwritew (regwritew),
    .forwardae (forwardae),
    .forwardbe (forwardbe)
  );

  assign macc    = memwritem || (resultsrcm == RES_LOAD);
  assign lwstall = (resultsrce == RES_LOAD) && (rde != 5'd0) &&
                   ((rs1d == rde) || (rs2d == rde));

  // Memory handshake decode. The first RUN cycle of an unready access
  // already counts as a stall, so wcnt==N in WAIT means N cycles stalled;
  // reaching TIMEOUT releases the pipe instead of stalling once more.
  always_comb begin
    dmem_req = 1'b0;
    memstall = 1'b0;
    abort    = 1'b0;
    case (state)
      S_RUN: begin
        dmem_req = macc;
        memstall = macc && !dmem_ready;
      end
      S_WAIT: begin
        dmem_req = 1'b1;
        if (!dmem_ready) begin
          if (wcnt == WCNT_MAX) begin
            abort = 1'b1;
          end else begin
            memstall = 1'b1;
          end
        end
      end
      default: begin
        dmem_req = 1'b0;
      end
    endcase
  end

  // Stall/flush priority: memory freeze, then redirect, then load-use.
  always_comb begin
    stallf = 1'b0;
    stalld = 1'b0;
    stalle = 1'b0;
    stallm = 1'b0;
    flushd = 1'b0;
    flushe = 1'b0;
    flushw = 1'b0;
    if (memstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      stalle = 1'b1;
      stallm = 1'b1;
      flushw = 1'b1;  // W retires a bubble while M holds
    end else if (pcsrce) begin
      flushd = 1'b1;
      flushe = 1'b1;
    end else if (lwstall) begin
      stallf = 1'b1;
      stalld = 1'b1;
      flushe = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_RUN;
      wcnt    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        S_RUN: begin
          if (memstall) begin
            state <= S_WAIT;
            wcnt  <= WCNT_ONE;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            state <= S_RUN;
          end else if (abort) begin
            // Pipe advances as if the access completed; flag it for software.
            state   <= S_RUN;
            mem_err <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_ONE;
          end
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if (stalld && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl with a queue-based scoreboard.
// Latency: driver changes inputs 1 time unit after posedge; monitor samples on negedge.
// Backpressure: n/a.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  // Packed stall/flush view: {stallf,stalld,stalle,stallm,flushd,flushe,flushw}
  localparam logic [6:0] ST_NONE = 7'b0000000;
  localparam logic [6:0] ST_MEM  = 7'b1111001;
  localparam logic [6:0] ST_BR   = 7'b0000110;
  localparam logic [6:0] ST_LU   = 7'b1100010;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [4:0]       rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
  logic [1:0]       resultsrce, resultsrcm;
  logic             pcsrce, regwritem, regwritew, memwritem, dmem_ready;
  logic             dmem_req;
  logic [1:0]       forwardae, forwardbe;
  logic             stallf, stalld, stalle, stallm, flushd, flushe, flushw;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rs1d       (rs1d),
    .rs2d       (rs2d),
    .rs1e       (rs1e),
    .rs2e       (rs2e),
    .rde        (rde),
    .resultsrce (resultsrce),
    .pcsrce     (pcsrce),
    .rdm        (rdm),
    .rdw        (rdw),
    .regwritem  (regwritem),
    .regwritew  (regwritew),
    .memwritem  (memwritem),
    .resultsrcm (resultsrcm),
    .dmem_ready (dmem_ready),
    .dmem_req   (dmem_req),
    .forwardae  (forwardae),
    .forwardbe  (forwardbe),
    .stallf     (stallf),
    .stalld     (stalld),
    .stalle     (stalle),
    .stallm     (stallm),
    .flushd     (flushd),
    .flushe     (flushe),
    .flushw     (flushw),
    .mem_err    (mem_err),
    .stall_cnt  (stall_cnt)
  );

  typedef struct {
    int               id;
    logic [6:0]       st;
    logic             req;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               vec_id   = 0;
  logic [CNT_W-1:0] exp_cnt;
  logic             exp_err;
  logic [6:0]       st_act;

  assign st_act = {stallf, stalld, stalle, stallm, flushd, flushe, flushw};

  task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL vec%0d %s: got %0h want %0h", id, nm, act, want);
    end
  endtask

  // Monitor: one scoreboard entry per presented cycle.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp("stall_flush", e.id, 32'(st_act),    32'(e.st));
      cmp("dmem_req",    e.id, 32'(dmem_req),  32'(e.req));
      cmp("forwardae",   e.id, 32'(forwardae), 32'(e.fa));
      cmp("forwardbe",   e.id, 32'(forwardbe), 32'(e.fb));
      cmp("mem_err",     e.id, 32'(mem_err),   32'(e.err));
      cmp("stall_cnt",   e.id, 32'(stall_cnt), 32'(e.cnt));
    end
  end

  // Push the expectation for the current cycle; stall_cnt expectation then
  // advances for the next cycle if this one stalls D.
  task automatic expect_now(input logic [6:0] st, input logic req, input logic [1:0] fa, input logic [1:0] fb);
    exp_t e;
    e.id  = vec_id;
    e.st  = st;
    e.req = req;
    e.fa  = fa;
    e.fb  = fb;
    e.err = exp_err;
    e.cnt = exp_cnt;
    sb.push_back(e);
    vec_id++;
    if (st[5] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [6:0] st, input logic req, input logic [1:0] fa, input logic [1:0] fb);
    expect_now(st, req, fa, fb);
    next_cycle();
  endtask

  task automatic clr();
    rs1d = 5'd0; rs2d = 5'd0; rs1e = 5'd0; rs2e = 5'd0; rde = 5'd0;
    rdm = 5'd0; rdw = 5'd0; resultsrce = 2'b00; resultsrcm = 2'b00;
    pcsrce = 1'b0; regwritem = 1'b0; regwritew = 1'b0; memwritem = 1'b0;
    dmem_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    clr();
    exp_cnt = '0;
    exp_err = 1'b0;
    next_cycle();

    // Reset state
    step(ST_NONE, 1'b0, 2'b00, 2'b00);
    reset_n = 1'b1;

    // Forwarding: M over W, W alone, x0 never forwarded
    rdm = 5'd5; regwritem = 1'b1; rdw = 5'd5; regwritew = 1'b1; rs1e = 5'd5; rs2e = 5'd5;
    step(ST_NONE, 1'b0, 2'b10, 2'b10);
    regwritem = 1'b0;
    step(ST_NONE, 1'b0, 2'b01, 2'b01);
    rs1e = 5'd0;
    step(ST_NONE, 1'b0, 2'b00, 2'b01);
    rs1e = 5'd9; rdw = 5'd9; regwritew = 1'b0; rs2e = 5'd3; rdm = 5'd3; regwritem = 1'b1;
    step(ST_NONE, 1'b0, 2'b00, 2'b10);
    rs2e = 5'd0; rdm = 5'd0; regwritew = 1'b1;
    step(ST_NONE, 1'b0, 2'b01, 2'b00);
    clr();

    // Timeout: 4 stalled cycles, release in the 5th, mem_err after that edge
    resultsrcm = 2'b01;
    for (int i = 0; i < TIMEOUT; i++) step(ST_MEM, 1'b1, 2'b00, 2'b00);
    step(ST_NONE, 1'b1, 2'b00, 2'b00);
    exp_err = 1'b1;
    clr();
    step(ST_NONE, 1'b0, 2'b00, 2'b00);

    // Zero-wait, back-to-back accesses
    memwritem = 1'b1; dmem_ready = 1'b1;
    step(ST_NONE, 1'b1, 2'b00, 2'b00);
    memwritem = 1'b0; resultsrcm = 2'b01;
    step(ST_NONE, 1'b1, 2'b00, 2'b00);

    // Memory wait of 3 cycles; redirect and load-use masked by the freeze
    resultsrcm = 2'b00; memwritem = 1'b1; dmem_ready = 1'b0;
    step(ST_MEM, 1'b1, 2'b00, 2'b00);
    pcsrce = 1'b1; resultsrce = 2'b01; rde = 5'd7; rs1d = 5'd7;
    step(ST_MEM, 1'b1, 2'b00, 2'b00);
    pcsrce = 1'b0; resultsrce = 2'b00; rde = 5'd0; rs1d = 5'd0;
    step(ST_MEM, 1'b1, 2'b00, 2'b00);
    dmem_ready = 1'b1;
    step(ST_NONE, 1'b1, 2'b00, 2'b00);
    clr();
    step(ST_NONE, 1'b0, 2'b00, 2'b00);

    // Reset mid-WAIT (wcnt=2, stall_cnt=9): pulse clears between edges
    memwritem = 1'b1;
    step(ST_MEM, 1'b1, 2'b00, 2'b00);
    step(ST_MEM, 1'b1, 2'b00, 2'b00);
    expect_now(ST_MEM, 1'b1, 2'b00, 2'b00);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    memwritem = 1'b0; resultsrce = 2'b01; rde = 5'd7; rs2d = 5'd7;
    #2;
    reset_n = 1'b1;
    exp_err = 1'b0;
    exp_cnt = 1;  // the edge after the pulse counts the load-use stall
    next_cycle();

    // Load-use, guards, branch, branch beating load-use
    step(ST_LU, 1'b0, 2'b00, 2'b00);
    rs2d = 5'd0; rs1d = 5'd7;
    step(ST_LU, 1'b0, 2'b00, 2'b00);
    rde = 5'd0; rs1d = 5'd0;
    step(ST_NONE, 1'b0, 2'b00, 2'b00);
    resultsrce = 2'b10; rde = 5'd7; rs1d = 5'd7;
    step(ST_NONE, 1'b0, 2'b00, 2'b00);
    resultsrce = 2'b00; pcsrce = 1'b1;
    step(ST_BR, 1'b0, 2'b00, 2'b00);
    resultsrce = 2'b01;
    step(ST_BR, 1'b0, 2'b00, 2'b00);
    pcsrce = 1'b0;

    // Saturation of stall_cnt at all-ones
    for (int i = 0; i < 14; i++) step(ST_LU, 1'b0, 2'b00, 2'b00);
    clr();
    step(ST_NONE, 1'b0, 2'b00, 2'b00);

    cmp("scoreboard_drain", vec_id, 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It produces the stall and flush enables for the F/D, D/E, E/M and M/W pipeline registers, and the EX-stage forwarding selects. It also runs the request/ready handshake with a variable-latency data memory, freezing the pipe while an access in MEM is outstanding. It sits beside the datapath and reads the control bits carried in the D/E, E/M and M/W control registers.

## Interface
- TIMEOUT, 255: maximum stalled cycles for one data-memory access before it is aborted (≥2).
- CNT_W, 16: width of the stall-cycle performance counter.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs1d, rs2d  in  5  source registers of the instruction in D.
- rs1e, rs2e, rde  in  5  source and destination registers of the instruction in E.
- resultsrce  in  2  result select of E (00 ALU, 01 load, 10 PC+4).
- pcsrce  in  1  taken branch/jump resolved in E.
- rdm, rdw  in  5  destinations in M and W.
- regwritem, regwritew  in  1  write enables in M and W.
- memwritem  in  1  store in M.
- resultsrcm  in  2  result select of M.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  access outstanding in M.
- forwardae, forwardbe  out  2  EX operand select (00 register file, 01 W result, 10 M ALU result).
- stallf, stalld, stalle, stallm  out  1  hold the PC, F/D, D/E and E/M registers.
- flushd, flushe, flushw  out  1  clear F/D, D/E and M/W to a bubble.
- mem_err  out  1  sticky: an access hit TIMEOUT.
- stall_cnt  out  CNT_W  saturating count of cycles with stalld=1.

## Operation
- **Forwarding (combinational).** forwardae = 10 if rs1e≠0 && regwritem && rs1e==rdm. Otherwise 01 if rs1e≠0 && regwritew && rs1e==rdw. Otherwise 00. forwardbe is identical using rs2e. M has priority over W.
- **Load-use.** lwstall = (resultsrce==01) && rde≠0 && (rs1d==rde || rs2d==rde).
- **Memory access.** macc = memwritem || resultsrcm==01.
- **FSM states.** RUN and WAIT, plus wait counter wcnt of width clog2(TIMEOUT+1).
- **RUN.** dmem_req=macc.
  - macc && !dmem_ready: memstall=1, go to WAIT, wcnt←1.
  - Otherwise stay in RUN.
- **WAIT.** dmem_req=1.
  - dmem_ready: memstall=0, go to RUN.
  - Else if wcnt==TIMEOUT: abort. memstall=0, go to RUN, mem_err←1.
  - Else: memstall=1, wcnt←wcnt+1.
- **Output priority, highest first:**
  - memstall: stallf=stalld=stalle=stallm=1, flushw=1, flushd=flushe=0.
  - pcsrce: flushd=flushe=1, stallf=stalld=0.
  - lwstall: stallf=stalld=1, flushe=1.
  - Otherwise all stall/flush outputs are 0. stalle, stallm and flushw are 1 only under memstall.
- **pcsrce and lwstall.** These cannot legally coincide. If both are asserted, pcsrce wins as listed.
- **Abort.** An aborted access lets the pipe advance as if dmem_ready had been asserted; read data is undefined.
- **Counters.** stall_cnt increments every cycle stalld=1 and saturates at all-ones. mem_err clears only on reset.

## Timing
- forwarding, stall, flush and dmem_req are combinational from inputs and state, all in the same cycle.
- State, wcnt, mem_err and stall_cnt update on the rising edge of clk.
- **Zero-wait access:** dmem_ready high in the RUN cycle that macc is first seen gives no stall.
- **Stall length:** an access stalls exactly N cycles when dmem_ready arrives N cycles after first presentation, N < TIMEOUT. It never stalls more than TIMEOUT cycles.
- dmem_req stays high from first presentation through the ready (or abort) cycle.
- The RUN after WAIT sees the next instruction in M; back-to-back accesses are legal.
- **Reset (reset_n low), at any time including mid-WAIT:** state=RUN, wcnt=0, mem_err=0, stall_cnt=0. Combinational outputs then follow their inputs with memstall=0.

## Structure
- **Shared package:**
  - result-select encodings RES_ALU/RES_LOAD/RES_PC4;
  - forward encodings FWD_RF/FWD_W/FWD_M;
  - FSM state constants S_RUN/S_WAIT.
- **Sub-module:** one purely combinational `hz_forward`, instantiated once and computing both select pairs. The FSM, stall priority and counters stay in `hazard_ctrl`.

## Test plan
- **Forwarding.** rdm=5, regwritem=1, rdw=5, regwritew=1, rs1e=5 -> forwardae=10. Drop regwritem -> 01. Set rs1e=0 -> 00.
- **Load-use.** resultsrce=01, rde=7, rs2d=7 -> stallf=stalld=flushe=1 for one cycle; stall_cnt goes 0 to 1.
- **Branch.** pcsrce=1 -> flushd=flushe=1, stallf=0, stall_cnt unchanged.
- **Memory wait.** memwritem=1, dmem_ready low for 3 cycles then high -> 3 cycles with all stalls and flushw=1. dmem_req is high for 4 cycles. The FSM is in RUN after the ready edge.
- **Timeout.** TIMEOUT=4, resultsrcm=01, dmem_ready never rises -> 4 stalled cycles, release in the 5th. mem_err=1 after that edge and stays 1 through later traffic.
- **Reset mid-WAIT.** Drop reset_n in WAIT with wcnt=2 and stall_cnt=9 -> immediately state RUN, mem_err=0, stall_cnt=0, and stall outputs follow inputs with memstall=0.
